// File: rtl/dbg_cmd_master_pkg.sv
// Shared types and constants for the debug-bus command master.
package dbg_cmd_master_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [3:0] {
    SEG_CTL = 4'h1,
    SEG_ROM = 4'h2,
    SEG_RAM = 4'h3
  } seg_t;

  typedef enum logic [1:0] {
    OP_PING  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WR_DATA,
    ST_WR_STROBE,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_RD_SEND,
    ST_RESP
  } state_e;

  localparam addr_t Park_addr        = {4'hF, 12'h000};
  localparam addr_t Ctl_sys_rst_addr = {SEG_CTL, 12'h000};

  localparam byte_t Ack  = 8'h06;
  localparam byte_t Nak  = 8'h15;
  localparam byte_t Ping = 8'hA5;

  // Segment is fixed for the packet; only the 12-bit offset advances and wraps.
  function automatic addr_t addr_inc(input addr_t a);
    return {a[15:12], a[11:0] + 12'd1};
  endfunction

endpackage

// File: rtl/dbg_cmd_master_txreg.sv
// One-entry valid/ready output register shared by response codes and read data.
module dbg_byte_txreg
  import dbg_cmd_master_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  byte_t i_data,
  output byte_t o_data,
  output logic  o_valid,
  input  logic  i_ready
);

  logic  r_valid;
  byte_t r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dbg_cmd_master.sv
// Debug-bus initiator: host byte packets -> debug-bus reads/writes plus response bytes.
// Optional inter-byte timeout enabled by defining DBG_CMD_TIMEOUT_EN.
module dbg_cmd_master
  import dbg_cmd_master_pkg::*;
#(
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic  clk,
  input  logic  rst,
  input  byte_t rx_data,
  input  logic  rx_valid,
  output logic  rx_ready,
  output byte_t tx_data,
  output logic  tx_valid,
  input  logic  tx_ready,
  output addr_t dbg_addr,
  output logic  dbg_wen,
  output byte_t dbg_wdata,
  input  byte_t dbg_rdata,
  output logic  busy
);

  // One counter serves both read latency and (optionally) the inter-byte timeout.
  localparam int unsigned WAIT_MAX = (RD_LAT > TIMEOUT_CYCLES) ? RD_LAT : TIMEOUT_CYCLES;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(RD_LAT - 1);

  state_e            r_state, w_state_nxt;
  addr_t             r_cur;
  logic [5:0]        r_len;
  logic              r_is_wr;
  byte_t             r_wdata;
  logic [WAIT_W-1:0] r_wait;

  logic  w_rx_fire, w_tx_fire, w_tx_load, w_wait_run;
  byte_t w_tx_byte;

  assign rx_ready  = !rst && (r_state == ST_IDLE || r_state == ST_ADDR_HI ||
                              r_state == ST_ADDR_LO || r_state == ST_WR_DATA);
  assign w_rx_fire = rx_valid && rx_ready;
  assign w_tx_fire = tx_valid && tx_ready;

  // The ROM write enable decodes on segment alone, so the address is parked outside accesses.
  assign dbg_addr  = (r_state == ST_WR_STROBE || r_state == ST_RD_ADDR ||
                      r_state == ST_RD_CAP || r_state == ST_RD_SEND) ? r_cur : Park_addr;
  assign dbg_wen   = (r_state == ST_WR_STROBE);
  assign dbg_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);

`ifdef DBG_CMD_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic w_waiting;
  assign w_waiting  = (r_state == ST_ADDR_HI || r_state == ST_ADDR_LO || r_state == ST_WR_DATA);
  assign w_wait_run = (r_state == ST_RD_ADDR) || w_waiting;
`else
  assign w_wait_run = (r_state == ST_RD_ADDR);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tx_load   = 1'b0;
    w_tx_byte   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_fire) begin
          unique case (op_e'(rx_data[7:6]))
            OP_PING: begin
              w_state_nxt = ST_RESP;
              w_tx_load   = 1'b1;
              w_tx_byte   = Ping;
            end
            OP_RSVD: begin
              w_state_nxt = ST_RESP;
              w_tx_load   = 1'b1;
              w_tx_byte   = Nak;
            end
            default: w_state_nxt = ST_ADDR_HI;
          endcase
        end
      end
      ST_ADDR_HI: if (w_rx_fire) w_state_nxt = ST_ADDR_LO;
      ST_ADDR_LO: if (w_rx_fire) w_state_nxt = r_is_wr ? ST_WR_DATA : ST_RD_ADDR;
      ST_WR_DATA: if (w_rx_fire) w_state_nxt = ST_WR_STROBE;
      ST_WR_STROBE: begin
        if (r_len == 6'd0) begin
          w_state_nxt = ST_RESP;
          w_tx_load   = 1'b1;
          w_tx_byte   = Ack;
        end else begin
          w_state_nxt = ST_WR_DATA;
        end
      end
      ST_RD_ADDR: if (r_wait == LAT_LAST) w_state_nxt = ST_RD_CAP;
      ST_RD_CAP: begin
        w_state_nxt = ST_RD_SEND;
        w_tx_load   = 1'b1;
        w_tx_byte   = dbg_rdata;
      end
      ST_RD_SEND: if (w_tx_fire) w_state_nxt = (r_len == 6'd0) ? ST_IDLE : ST_RD_ADDR;
      ST_RESP:    if (w_tx_fire) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
`ifdef DBG_CMD_TIMEOUT_EN
    if (w_waiting && !w_rx_fire && r_wait == TMO_LAST) begin
      w_state_nxt = ST_RESP;
      w_tx_load   = 1'b1;
      w_tx_byte   = Nak;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= Park_addr;
      r_len   <= '0;
      r_is_wr <= 1'b0;
      r_wdata <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || w_rx_fire) r_wait <= '0;
      else if (w_wait_run)                     r_wait <= r_wait + WAIT_W'(1);
      if (w_rx_fire) begin
        unique case (r_state)
          ST_IDLE: begin
            r_is_wr <= (rx_data[7:6] == OP_WRITE);
            r_len   <= rx_data[5:0];
          end
          ST_ADDR_HI: r_cur[15:8] <= rx_data;
          ST_ADDR_LO: r_cur[7:0]  <= rx_data;
          ST_WR_DATA: r_wdata     <= rx_data;
          default: ;
        endcase
      end
      if (r_state == ST_WR_STROBE || (r_state == ST_RD_SEND && w_tx_fire)) begin
        r_cur <= addr_inc(r_cur);
        r_len <= r_len - 6'd1;
      end
    end
  end

  dbg_byte_txreg u_txreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tx_load),
    .i_data  (w_tx_byte),
    .o_data  (tx_data),
    .o_valid (tx_valid),
    .i_ready (tx_ready)
  );

endmodule

// File: tb/tb_dbg_cmd_master.sv
// Directed self-checking bench for dbg_cmd_master with a registered memory responder.
module tb_dbg_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] dbg_addr;
  logic        dbg_wen;
  logic [7:0]  dbg_wdata;
  logic [7:0]  dbg_rdata = '0;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] wr_log [$];
  int unsigned n_consec  = 0;
  int unsigned n_nonpark = 0;
  logic        prev_wen  = 1'b0;

  always #5 clk = ~clk;

  dbg_cmd_master #(.RD_LAT(1), .TIMEOUT_CYCLES(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dbg_addr  (dbg_addr),
    .dbg_wen   (dbg_wen),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (dbg_wen) mem[dbg_addr] <= dbg_wdata;
    dbg_rdata <= mem[dbg_addr];
  end

  always @(negedge clk) begin
    if (dbg_wen) wr_log.push_back({dbg_addr, dbg_wdata});
    if (dbg_wen && prev_wen) n_consec++;
    prev_wen = dbg_wen;
    if (dbg_addr != 16'hF000) n_nonpark++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check({tag, " rx accepted"}, 32'(ok), 32'd1);
  endtask

  task automatic recv_check(input string tag, input logic [7:0] exp);
    logic ok;
    logic [7:0] b;
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        ok = 1'b1;
        b  = tx_data;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " tx handshake"}, 32'(ok), 32'd1);
    check({tag, " tx byte"}, 32'(b), 32'(exp));
  endtask

  task automatic clear_monitors();
    wr_log.delete();
    n_consec  = 0;
    n_nonpark = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned stall_bad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1000] = 8'h07;
    mem[16'h1FFE] = 8'hA1;
    mem[16'h1FFF] = 8'hB2;
    mem[16'h1001] = 8'hC4;

    repeat (3) @(negedge clk);
    check("rst rx_ready",  32'(rx_ready),  32'd0);
    check("rst dbg_addr",  32'(dbg_addr),  32'hF000);
    check("rst dbg_wen",   32'(dbg_wen),   32'd0);
    check("rst dbg_wdata", 32'(dbg_wdata), 32'd0);
    check("rst tx_valid",  32'(tx_valid),  32'd0);
    check("rst tx_data",   32'(tx_data),   32'd0);
    check("rst busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    clear_monitors();

    send_byte("ping", 8'h00);
    recv_check("ping", 8'hA5);
    @(negedge clk);
    check("ping busy", 32'(busy), 32'd0);
    check("ping no wen", 32'(wr_log.size()), 32'd0);
    @(posedge clk);
    #1;

    send_byte("rd_rst op", 8'h80);
    send_byte("rd_rst hi", 8'h10);
    send_byte("rd_rst lo", 8'h00);
    recv_check("rd_rst", 8'h07);

    clear_monitors();
    send_byte("wr op", 8'h42);
    send_byte("wr hi", 8'h20);
    send_byte("wr lo", 8'hFE);
    send_byte("wr d0", 8'h11);
    send_byte("wr d1", 8'h22);
    send_byte("wr d2", 8'h33);
    recv_check("wr ack", 8'h06);
    check("wr strobe count", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("wr strobe0", 32'(wr_log[0]), 32'h20FE11);
      check("wr strobe1", 32'(wr_log[1]), 32'h20FF22);
      check("wr strobe2", 32'(wr_log[2]), 32'h210033);
    end
    check("wr unparked cycles", n_nonpark, 32'd3);
    check("wr wen consecutive", n_consec, 32'd0);
    check("wr mem 0x2100", 32'(mem[16'h2100]), 32'h33);

    clear_monitors();
    tx_ready = 1'b0;
    send_byte("rdb op", 8'h83);
    send_byte("rdb hi", 8'h1F);
    send_byte("rdb lo", 8'hFE);
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_addr != 16'h1FFE || dbg_wen) stall_bad++;
    end
    check("rdb stall addr held", stall_bad, 32'd0);
    check("rdb stall tx_valid", 32'(tx_valid), 32'd1);
    check("rdb stall tx_data", 32'(tx_data), 32'hA1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    recv_check("rdb b0", 8'hA1);
    recv_check("rdb b1", 8'hB2);
    recv_check("rdb b2 wrap", 8'h07);
    recv_check("rdb b3", 8'hC4);
    @(negedge clk);
    check("rdb busy", 32'(busy), 32'd0);
    check("rdb no wen", 32'(wr_log.size()), 32'd0);
    @(posedge clk);
    #1;

    clear_monitors();
    send_byte("rsvd op", 8'hC5);
    recv_check("rsvd", 8'h15);
    @(negedge clk);
    check("rsvd busy", 32'(busy), 32'd0);
    check("rsvd no access", n_nonpark, 32'd0);
    @(posedge clk);
    #1;

    clear_monitors();
    send_byte("rstw op", 8'h41);
    send_byte("rstw hi", 8'h30);
    send_byte("rstw lo", 8'h10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstw async busy", 32'(busy), 32'd0);
    check("rstw async rx_ready", 32'(rx_ready), 32'd0);
    check("rstw async dbg_addr", 32'(dbg_addr), 32'hF000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send_byte("rstw ping", 8'h00);
    recv_check("rstw ping", 8'hA5);
    check("rstw no wen", 32'(wr_log.size()), 32'd0);

`ifdef DBG_CMD_TIMEOUT_EN
    clear_monitors();
    send_byte("tmo op", 8'h41);
    send_byte("tmo hi", 8'h30);
    recv_check("tmo nak", 8'h15);
    check("tmo no wen", 32'(wr_log.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
